pipe_hazard_ctrl: RTL and testbench
===================================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter WAIT_LIMIT, default 255, meaning the maximum data-memory wait cycles before error.
REQ-002 SHALL have parameter CNT_W, default 16, meaning the width of each statistics counter.
REQ-003 SHALL have port clk_i, input, 1, the single system clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_i, input, 1, synchronous active-high reset.
REQ-005 SHALL have port id_rs_i, input, 5, rs field of the instruction in ID.
REQ-006 SHALL have port id_rt_i, input, 5, rt field of the instruction in ID.
REQ-007 SHALL have port id_uses_rt_i, input, 1, ID instruction reads rt (R-type, beq, sw).
REQ-008 SHALL have port ex_memread_i, input, 1, instruction in EX is a load.
REQ-009 SHALL have port ex_rt_i, input, 5, destination rt of the load in EX.
REQ-010 SHALL have port mem_branch_taken_i, input, 1, Branch AND zero in MEM.
REQ-011 SHALL have port mem_req_i, input, 1, MemRead OR MemWrite in MEM.
REQ-012 SHALL have port dmem_ready_i, input, 1, data memory has completed the current access.
REQ-013 SHALL have port pc_write_o, output, 1, PC load enable.
REQ-014 SHALL have port if_id_write_o, output, 1, IF/ID register load enable.
REQ-015 SHALL have ports if_id_flush_o, id_ex_flush_o and ex_mem_flush_o, each output, 1, clearing the control fields of the named pipe register to a bubble.
REQ-016 SHALL have port pipe_hold_o, output, 1, freezing ID/EX, EX/MEM and MEM/WB.
REQ-017 SHALL have port err_o, output, 1, sticky memory-timeout flag.
REQ-018 SHALL have ports stall_cnt_o, flush_cnt_o and wait_cnt_o, each output, CNT_W, statistics counters.

Function
REQ-019 SHALL implement FSM states RUN, WAIT and ERR; outputs SHALL be a combinational function of state and inputs, and state and counters SHALL be registered.
REQ-020 SHALL define memory stall as mem_req_i=1 and dmem_ready_i=0 while in RUN or WAIT.
REQ-021 SHALL define branch flush as mem_branch_taken_i=1 with no memory stall.
REQ-022 SHALL define load-use as ex_memread_i=1, ex_rt_i!=0, and (ex_rt_i==id_rs_i or (id_uses_rt_i=1 and ex_rt_i==id_rt_i)), with no memory stall and no branch flush.
REQ-023 SHALL apply priority memory stall > branch flush > load-use.
REQ-024 With no event in RUN or WAIT, SHALL drive pc_write_o=1, if_id_write_o=1 and all flush/hold outputs 0.
REQ-025 On memory stall, SHALL drive pc_write_o=0, if_id_write_o=0, pipe_hold_o=1 and flushes 0; next state WAIT.
REQ-026 In WAIT with dmem_ready_i=1, SHALL behave as RUN for that cycle (including acting on a pending branch flush) and return to RUN.
REQ-027 SHALL maintain a wait-cycle counter that is zeroed on entry to WAIT; when it reaches WAIT_LIMIT, SHALL set err_o and enter ERR.
REQ-028 In ERR, SHALL drive pc_write_o=0, if_id_write_o=0 and pipe_hold_o=1 permanently until reset.
REQ-029 On branch flush, SHALL drive pc_write_o=1 and if_id_flush_o=id_ex_flush_o=ex_mem_flush_o=1 for exactly that cycle.
REQ-030 On load-use, SHALL drive pc_write_o=0, if_id_write_o=0 and id_ex_flush_o=1 for one cycle, producing exactly one bubble.
REQ-031 SHALL increment stall_cnt_o per load-use cycle, flush_cnt_o per branch-flush cycle and wait_cnt_o per memory-stall cycle, each saturating at all-ones.

Reset
REQ-032 On rst_i=1 at a clock edge, SHALL enter RUN and clear err_o, all counters and the wait-cycle counter, including mid-WAIT or in ERR.
REQ-033 While rst_i=1, SHALL drive pc_write_o=0, if_id_write_o=0, all flush outputs 0 and pipe_hold_o=0.

Structure
REQ-034 SHALL take the FSM state encoding type and the WAIT_LIMIT default from a shared CPU package.
REQ-035 SHALL instantiate the statistics counters as three copies of one sub-module, sat_counter.

Verification
REQ-036 Bench SHALL cover: lw $2 in EX with ID add reading rs=2 -> one cycle of pc_write_o=0, id_ex_flush_o=1, then stall_cnt_o=1.
REQ-037 Bench SHALL cover: ex_rt_i=0 load with id_rs_i=0 -> no stall.
REQ-038 Bench SHALL cover: mem_branch_taken_i=1 concurrently with load-use -> only the three flushes assert, flush_cnt_o=1, stall_cnt_o=0.
REQ-039 Bench SHALL cover: mem_req_i=1 with dmem_ready_i low for 3 cycles -> 3 cycles of pipe_hold_o=1, wait_cnt_o=3, then RUN.
REQ-040 Bench SHALL cover: dmem_ready_i held low for more than 255 cycles -> err_o=1 and permanent hold; rst_i pulse -> RUN, err_o=0, counters 0.
REQ-041 Bench SHALL cover: branch pending in MEM during WAIT -> flushes asserted only in the cycle dmem_ready_i rises.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared CPU definitions for the pipeline hazard controller.
// Holds the controller state encoding and the default memory-wait limit.
package pipe_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        S_RUN  = 2'd0,
        S_WAIT = 2'd1,
        S_ERR  = 2'd2
    } hz_state_e;

    localparam int WAIT_LIMIT_DEF = 255;

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter used for the hazard statistics.
// Synchronous clear; holds at all-ones.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_o <= '0;
        end else if (inc_i && (cnt_o != '1)) begin
            cnt_o <= cnt_o + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard control for a 5-stage pipeline: load-use stall, branch flush,
// data-memory wait with timeout, and statistics counters.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int WAIT_LIMIT = WAIT_LIMIT_DEF,
    parameter int CNT_W      = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [4:0]       id_rs_i,
    input  logic [4:0]       id_rt_i,
    input  logic             id_uses_rt_i,
    input  logic             ex_memread_i,
    input  logic [4:0]       ex_rt_i,
    input  logic             mem_branch_taken_i,
    input  logic             mem_req_i,
    input  logic             dmem_ready_i,
    output logic             pc_write_o,
    output logic             if_id_write_o,
    output logic             if_id_flush_o,
    output logic             id_ex_flush_o,
    output logic             ex_mem_flush_o,
    output logic             pipe_hold_o,
    output logic             err_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o,
    output logic [CNT_W-1:0] wait_cnt_o
);

    localparam int WW = $clog2(WAIT_LIMIT + 1);

    hz_state_e       state_q, state_d;
    logic [WW-1:0]   wcnt_q, wcnt_d;
    logic            active, in_err;
    logic            mem_stall, br_flush, load_use, rs_hit, rt_hit;

    // Events only exist while running; reset and ERR mask them all.
    always_comb begin
        active    = !rst_i && (state_q != S_ERR);
        in_err    = !rst_i && (state_q == S_ERR);
        rs_hit    = (ex_rt_i == id_rs_i);
        rt_hit    = id_uses_rt_i && (ex_rt_i == id_rt_i);
        mem_stall = active && mem_req_i && !dmem_ready_i;
        br_flush  = active && mem_branch_taken_i && !mem_stall;
        load_use  = active && ex_memread_i && (ex_rt_i != 5'd0)
                    && (rs_hit || rt_hit) && !mem_stall && !br_flush;
    end

    always_comb begin
        pc_write_o     = 1'b1;
        if_id_write_o  = 1'b1;
        if_id_flush_o  = 1'b0;
        id_ex_flush_o  = 1'b0;
        ex_mem_flush_o = 1'b0;
        pipe_hold_o    = 1'b0;
        unique case (1'b1)
            rst_i: begin
                pc_write_o    = 1'b0;
                if_id_write_o = 1'b0;
            end
            in_err, mem_stall: begin
                pc_write_o    = 1'b0;
                if_id_write_o = 1'b0;
                pipe_hold_o   = 1'b1;
            end
            br_flush: begin
                if_id_flush_o  = 1'b1;
                id_ex_flush_o  = 1'b1;
                ex_mem_flush_o = 1'b1;
            end
            load_use: begin
                pc_write_o    = 1'b0;
                if_id_write_o = 1'b0;
                id_ex_flush_o = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        unique case (state_q)
            S_RUN: begin
                if (mem_stall) begin
                    state_d = S_WAIT;
                    wcnt_d  = '0;
                end
            end
            S_WAIT: begin
                if (mem_stall) begin
                    wcnt_d = wcnt_q + 1'b1;
                    if (wcnt_d == WW'(WAIT_LIMIT)) begin
                        state_d = S_ERR;
                    end
                end else begin
                    state_d = S_RUN;
                end
            end
            S_ERR:   state_d = S_ERR;
            default: state_d = S_RUN;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_RUN;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
        end
    end

    assign err_o = (state_q == S_ERR);

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (load_use),
        .cnt_o (stall_cnt_o)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (br_flush),
        .cnt_o (flush_cnt_o)
    );

    sat_counter #(.W(CNT_W)) u_wait_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (mem_stall),
        .cnt_o (wait_cnt_o)
    );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Testbench for pipe_hazard_ctrl: directed scenarios plus random stimulus
// checked against a rule-level reference model.
module tb_pipe_hazard_ctrl;

    localparam int LIMIT = 255;
    localparam int CMAX  = 65535;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [4:0]  id_rs_i, id_rt_i, ex_rt_i;
    logic        id_uses_rt_i, ex_memread_i;
    logic        mem_branch_taken_i, mem_req_i, dmem_ready_i;
    logic        pc_write_o, if_id_write_o;
    logic        if_id_flush_o, id_ex_flush_o, ex_mem_flush_o;
    logic        pipe_hold_o, err_o;
    logic [15:0] stall_cnt_o, flush_cnt_o, wait_cnt_o;

    int checks = 0;
    int errors = 0;

    // reference model state
    bit m_err;
    int run_len;
    int m_stall, m_flush, m_wait;
    bit e_ms, e_bf, e_lu;

    always #5 clk_i = ~clk_i;

    pipe_hazard_ctrl dut (
        .clk_i              (clk_i),
        .rst_i              (rst_i),
        .id_rs_i            (id_rs_i),
        .id_rt_i            (id_rt_i),
        .id_uses_rt_i       (id_uses_rt_i),
        .ex_memread_i       (ex_memread_i),
        .ex_rt_i            (ex_rt_i),
        .mem_branch_taken_i (mem_branch_taken_i),
        .mem_req_i          (mem_req_i),
        .dmem_ready_i       (dmem_ready_i),
        .pc_write_o         (pc_write_o),
        .if_id_write_o      (if_id_write_o),
        .if_id_flush_o      (if_id_flush_o),
        .id_ex_flush_o      (id_ex_flush_o),
        .ex_mem_flush_o     (ex_mem_flush_o),
        .pipe_hold_o        (pipe_hold_o),
        .err_o              (err_o),
        .stall_cnt_o        (stall_cnt_o),
        .flush_cnt_o        (flush_cnt_o),
        .wait_cnt_o         (wait_cnt_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        rst_i = 1'b0;
        id_rs_i = 5'd0; id_rt_i = 5'd0; id_uses_rt_i = 1'b0;
        ex_memread_i = 1'b0; ex_rt_i = 5'd0;
        mem_branch_taken_i = 1'b0; mem_req_i = 1'b0; dmem_ready_i = 1'b1;
    endtask

    // Evaluate the hazard rules for the current inputs and compare.
    task automatic settle();
        bit run, hit;
        #1;
        run  = !rst_i && !m_err;
        hit  = (ex_rt_i == id_rs_i) || (id_uses_rt_i && ex_rt_i == id_rt_i);
        e_ms = run && mem_req_i && !dmem_ready_i;
        e_bf = run && mem_branch_taken_i && !e_ms;
        e_lu = run && ex_memread_i && ex_rt_i != 0 && hit && !e_ms && !e_bf;
        chk("pc_write", pc_write_o,
            !(rst_i || m_err || e_ms || e_lu));
        chk("if_id_write", if_id_write_o,
            !(rst_i || m_err || e_ms || e_lu));
        chk("if_id_flush", if_id_flush_o, e_bf);
        chk("id_ex_flush", id_ex_flush_o, e_bf || e_lu);
        chk("ex_mem_flush", ex_mem_flush_o, e_bf);
        chk("pipe_hold", pipe_hold_o, !rst_i && (m_err || e_ms));
        chk("err", err_o, m_err);
        chk("stall_cnt", stall_cnt_o, m_stall);
        chk("flush_cnt", flush_cnt_o, m_flush);
        chk("wait_cnt", wait_cnt_o, m_wait);
    endtask

    // Clock edge: advance the model by one cycle.
    task automatic tick();
        @(posedge clk_i);
        if (rst_i) begin
            m_err = 0; run_len = 0;
            m_stall = 0; m_flush = 0; m_wait = 0;
        end else begin
            if (e_lu && m_stall < CMAX) m_stall++;
            if (e_bf && m_flush < CMAX) m_flush++;
            if (e_ms && m_wait < CMAX) m_wait++;
            run_len = e_ms ? run_len + 1 : 0;
            if (run_len > LIMIT) m_err = 1;
        end
        @(negedge clk_i);
    endtask

    task automatic do_reset();
        idle();
        rst_i = 1'b1;
        settle();
        tick();
        rst_i = 1'b0;
    endtask

    initial begin
        idle();
        rst_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        m_err = 0; run_len = 0; m_stall = 0; m_flush = 0; m_wait = 0;

        // reset state
        settle();
        chk("rst_pc_write", pc_write_o, 1'b0);
        chk("rst_hold", pipe_hold_o, 1'b0);
        tick();
        idle();
        settle();
        chk("post_rst_err", err_o, 1'b0);
        chk("post_rst_stall", stall_cnt_o, 0);
        tick();

        // lw $2 in EX, add reading $2 in ID
        ex_memread_i = 1'b1; ex_rt_i = 5'd2; id_rs_i = 5'd2; id_rt_i = 5'd3;
        id_uses_rt_i = 1'b1;
        settle();
        chk("lu_pc_write", pc_write_o, 1'b0);
        chk("lu_id_ex_flush", id_ex_flush_o, 1'b1);
        tick();
        idle();
        settle();
        chk("lu_stall_cnt", stall_cnt_o, 1);
        chk("lu_release", pc_write_o, 1'b1);
        tick();

        // load targeting $0 never stalls
        do_reset();
        ex_memread_i = 1'b1; ex_rt_i = 5'd0; id_rs_i = 5'd0;
        settle();
        chk("r0_pc_write", pc_write_o, 1'b1);
        chk("r0_id_ex_flush", id_ex_flush_o, 1'b0);
        tick();

        // branch flush beats load-use
        do_reset();
        ex_memread_i = 1'b1; ex_rt_i = 5'd4; id_rs_i = 5'd4;
        mem_branch_taken_i = 1'b1;
        settle();
        chk("bf_if_id_flush", if_id_flush_o, 1'b1);
        chk("bf_ex_mem_flush", ex_mem_flush_o, 1'b1);
        chk("bf_pc_write", pc_write_o, 1'b1);
        tick();
        idle();
        settle();
        chk("bf_flush_cnt", flush_cnt_o, 1);
        chk("bf_stall_cnt", stall_cnt_o, 0);
        tick();

        // 3-cycle memory wait
        do_reset();
        mem_req_i = 1'b1; dmem_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("mw_hold", pipe_hold_o, 1'b1);
            tick();
        end
        dmem_ready_i = 1'b1;
        settle();
        chk("mw_ready_hold", pipe_hold_o, 1'b0);
        tick();
        idle();
        settle();
        chk("mw_wait_cnt", wait_cnt_o, 3);
        chk("mw_pc_write", pc_write_o, 1'b1);
        tick();

        // timeout into ERR, then recovery by reset
        do_reset();
        mem_req_i = 1'b1; dmem_ready_i = 1'b0;
        for (int i = 0; i < 300; i++) begin
            settle();
            tick();
        end
        dmem_ready_i = 1'b1; mem_branch_taken_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("to_err", err_o, 1'b1);
            chk("to_hold", pipe_hold_o, 1'b1);
            chk("to_pc_write", pc_write_o, 1'b0);
            tick();
        end
        chk("to_wait_cnt", wait_cnt_o, LIMIT + 1);
        do_reset();
        idle();
        settle();
        chk("rec_err", err_o, 1'b0);
        chk("rec_wait_cnt", wait_cnt_o, 0);
        chk("rec_pc_write", pc_write_o, 1'b1);
        tick();

        // branch pending in MEM while waiting on memory
        do_reset();
        mem_req_i = 1'b1; dmem_ready_i = 1'b0; mem_branch_taken_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            settle();
            chk("pw_no_flush", if_id_flush_o, 1'b0);
            tick();
        end
        dmem_ready_i = 1'b1;
        settle();
        chk("pw_flush", ex_mem_flush_o, 1'b1);
        chk("pw_if_id_flush", if_id_flush_o, 1'b1);
        tick();
        idle();
        settle();
        chk("pw_flush_cnt", flush_cnt_o, 1);
        chk("pw_after", id_ex_flush_o, 1'b0);
        tick();

        // random traffic
        for (int i = 0; i < 2000; i++) begin
            rst_i              = ($urandom_range(0, 199) == 0);
            id_rs_i            = 5'($urandom_range(0, 3));
            id_rt_i            = 5'($urandom_range(0, 3));
            ex_rt_i            = 5'($urandom_range(0, 3));
            id_uses_rt_i       = 1'($urandom_range(0, 1));
            ex_memread_i       = 1'($urandom_range(0, 1));
            mem_branch_taken_i = ($urandom_range(0, 5) == 0);
            mem_req_i          = ($urandom_range(0, 2) == 0);
            dmem_ready_i       = ($urandom_range(0, 3) != 0);
            settle();
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
